buffer_read_controller: RTL and testbench

- Reads a burst of `len` words from a synchronous-read buffer (psum/ifmap scratchpad) and streams them to a downstream consumer over a valid/ready handshake.
- It is the read-side counterpart of the buffer write controller: the PE array or the output path pulls data through it.
- Hides the buffer's 1-cycle read latency with a 2-entry skid buffer, so it sustains 1 word/cycle under no backpressure.

---
 rtl/buffer_read_controller_pkg.sv | 15 +
 rtl/buffer_read_controller_if.sv | 29 ++
 rtl/buffer_read_controller_skid.sv | 45 ++++
 rtl/buffer_read_controller.sv | 84 ++++++++
 tb/tb_buffer_read_controller.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/buffer_read_controller_pkg.sv
// Shared types and constants for the buffer read controller slice.
// State encoding and skid buffer sizing used by the controller and its FIFO.
package buffer_read_controller_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SKID_DEPTH = 2;
  localparam int OCC_W      = $clog2(SKID_DEPTH + 1);
  localparam int PTR_W      = $clog2(SKID_DEPTH);

endpackage

// File: rtl/buffer_read_controller_if.sv
// Handshake and buffer-side bundle between the read controller and its environment.
// The controller uses the slave view; the buffer/consumer side uses the master view.
interface buffer_read_controller_if #(
  parameter int DATA_W  = 16,
  parameter int COUNT_W = 8
);

  logic               start;
  logic [COUNT_W-1:0] len;
  logic               buf_empty;
  logic [DATA_W-1:0]  buf_rdata;
  logic               buf_ren;
  logic [DATA_W-1:0]  out_data;
  logic               out_valid;
  logic               out_ready;
  logic               busy;
  logic               done;

  modport slave (
    input  start, len, buf_empty, buf_rdata, out_ready,
    output buf_ren, out_data, out_valid, busy, done
  );

  modport master (
    output start, len, buf_empty, buf_rdata, out_ready,
    input  buf_ren, out_data, out_valid, busy, done
  );

endinterface

// File: rtl/buffer_read_controller_skid.sv
// Two-entry FIFO that absorbs buffer read data while the consumer stalls.
// Head data is forced to zero when empty so the output bus is quiet between words.
module read_skid_buffer
  import buffer_read_controller_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic [OCC_W-1:0]  occ
);

  logic [DATA_W-1:0] mem_q [SKID_DEPTH];
  logic [PTR_W-1:0]  rdPtr_q;
  logic [PTR_W-1:0]  wrPtr_q;
  logic [OCC_W-1:0]  occ_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      occ_q   <= '0;
    end else begin
      if (push) begin
        mem_q[wrPtr_q] <= din;
        wrPtr_q        <= wrPtr_q + PTR_W'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + PTR_W'(1);
      end
      occ_q <= occ_q + OCC_W'(push) - OCC_W'(pop);
    end
  end

  assign dout = (occ_q != '0) ? mem_q[rdPtr_q] : '0;
  assign occ  = occ_q;

endmodule

// File: rtl/buffer_read_controller.sv
// Burst reader: issues up to len buffer reads and streams the words out over valid/ready.
// Reads are throttled so in-flight data always has a free skid slot to land in.
module buffer_read_controller
  import buffer_read_controller_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int COUNT_W = 8
) (
  input logic                      clk,
  input logic                      rst,
  buffer_read_controller_if.slave  bus
);

  state_e             state_q;
  logic [COUNT_W-1:0] issueCnt_q;
  logic [COUNT_W-1:0] deliverCnt_q;
  logic               inflight_q;

  logic [OCC_W-1:0]   occ;
  logic               outValid;
  logic               fire;
  logic               bufRen;
  logic [OCC_W:0]     pending;

  assign outValid = (occ != '0);
  assign fire     = outValid & bus.out_ready;

  // Slots that will be taken after this edge if no new read is issued.
  assign pending = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q} - {{OCC_W{1'b0}}, fire};

  assign bufRen = (state_q == READ) && (issueCnt_q != '0) && !bus.buf_empty &&
                  (pending < (OCC_W+1)'(SKID_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      issueCnt_q   <= '0;
      deliverCnt_q <= '0;
      inflight_q   <= 1'b0;
    end else begin
      inflight_q <= bufRen;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            issueCnt_q   <= bus.len;
            deliverCnt_q <= bus.len;
            state_q      <= (bus.len == '0) ? DONE : READ;
          end
        end
        READ: begin
          if (bufRen) begin
            issueCnt_q <= issueCnt_q - COUNT_W'(1);
          end
          if (fire) begin
            deliverCnt_q <= deliverCnt_q - COUNT_W'(1);
            if (deliverCnt_q == COUNT_W'(1)) begin
              state_q <= DONE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  read_skid_buffer #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (inflight_q),
    .din  (bus.buf_rdata),
    .pop  (fire),
    .dout (bus.out_data),
    .occ  (occ)
  );

  assign bus.buf_ren   = bufRen;
  assign bus.out_valid = outValid;
  assign bus.busy      = (state_q == READ);
  assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_buffer_read_controller.sv
// Randomized bench for buffer_read_controller against a queue-level model of the burst.
// Directed bursts pin cycle-exact timing with literal expectations.
module tb_buffer_read_controller;

  localparam int DATA_W  = 16;
  localparam int COUNT_W = 8;

  logic clk = 1'b0;
  logic rst;

  buffer_read_controller_if #(.DATA_W(DATA_W), .COUNT_W(COUNT_W)) bus ();

  buffer_read_controller #(.DATA_W(DATA_W), .COUNT_W(COUNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int          cyc = 0;
  int          cycBase = 0;
  int          relD;
  int          relC;
  bit          renSeen = 1'b0;
  int          rdIdx = 0;
  logic [15:0] dataBase = 16'hD000;
  bit          detData = 1'b1;

  bit pendStart = 1'b0;
  int pendLen = 0;
  int readyOffUntil = -1;
  int emptyFrom = 1;
  int emptyTo = 0;
  bit randReady = 1'b0;
  bit randEmpty = 1'b0;
  int injAt = -1;
  int injLen = 9;

  logic [31:0] renVec, validVec, doneVec, busyVec;
  logic [15:0] dataAt9;
  logic [15:0] hsQ[$];
  int          doneCount = 0;

  // Abstract model: burst progress counters plus the queue of words awaiting delivery.
  int          mState = 0;
  int          mLen = 0;
  int          mIssued = 0;
  int          mDel = 0;
  bit          mInflight = 1'b0;
  logic [15:0] mQ[$];
  bit          eValid, eFire, eRen;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Environment: buffer, consumer and start generator, driven just after each rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (pendStart) begin
      cycBase   = cyc;
      bus.start = 1'b1;
      bus.len   = COUNT_W'(pendLen);
      pendStart = 1'b0;
    end else if (injAt >= 0 && (cyc - cycBase) == injAt) begin
      bus.start = 1'b1;
      bus.len   = COUNT_W'(injLen);
    end else begin
      bus.start = 1'b0;
      bus.len   = COUNT_W'($urandom);
    end
    relD = cyc - cycBase;
    if (relD <= readyOffUntil) bus.out_ready = 1'b0;
    else if (randReady)        bus.out_ready = ($urandom_range(0, 3) != 0);
    else                       bus.out_ready = 1'b1;
    if (relD >= emptyFrom && relD <= emptyTo) bus.buf_empty = 1'b1;
    else if (randEmpty)                       bus.buf_empty = ($urandom_range(0, 3) == 0);
    else                                      bus.buf_empty = 1'b0;
    if (renSeen) begin
      bus.buf_rdata = detData ? (dataBase + 16'(rdIdx)) : 16'($urandom);
      rdIdx++;
    end else begin
      bus.buf_rdata = 16'($urandom);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      renSeen = 1'b0;
    end else begin
      relC = cyc - cycBase;
      if (relC < 32) begin
        renVec[relC]   = bus.buf_ren;
        validVec[relC] = bus.out_valid;
        doneVec[relC]  = bus.done;
        busyVec[relC]  = bus.busy;
      end
      if (relC == 9) dataAt9 = bus.out_data;
      if (bus.done === 1'b1) doneCount++;
      if (bus.out_valid === 1'b1 && bus.out_ready) hsQ.push_back(bus.out_data);

      eValid = (mQ.size() != 0);
      eFire  = eValid && bus.out_ready;
      eRen   = (mState == 1) && (mIssued < mLen) && !bus.buf_empty &&
               ((mQ.size() + int'(mInflight) - int'(eFire)) < 2);

      checkOutput("out_valid", bus.out_valid, eValid);
      checkOutput("buf_ren", bus.buf_ren, eRen);
      checkOutput("busy", bus.busy, mState == 1);
      checkOutput("done", bus.done, mState == 2);
      if (eValid) checkOutput("out_data", bus.out_data, mQ[0]);

      if (eFire) begin
        void'(mQ.pop_front());
        mDel++;
      end
      if (mInflight) mQ.push_back(bus.buf_rdata);
      if (eRen) mIssued++;
      mInflight = eRen;
      case (mState)
        0: if (bus.start) begin
             mLen    = int'(bus.len);
             mIssued = 0;
             mDel    = 0;
             mState  = (bus.len == 0) ? 2 : 1;
           end
        1: if (eFire && mDel == mLen) mState = 2;
        default: mState = 0;
      endcase
      renSeen = bus.buf_ren;
    end
  end

  task automatic applyStimulus(input int L, input int offUntil, input int eFrom, input int eTo,
                               input bit rr, input bit re, input int inj, input bit waitDone);
    int d0;
    bit ok;
    d0 = doneCount;
    hsQ.delete();
    readyOffUntil = offUntil;
    emptyFrom     = eFrom;
    emptyTo       = eTo;
    randReady     = rr;
    randEmpty     = re;
    injAt         = inj;
    pendLen       = L;
    pendStart     = 1'b1;
    if (waitDone) begin
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        @(negedge clk);
        #1;
        if (doneCount > d0) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) checkOutput("done_timeout", 32'd0, 32'd1);
      repeat (3) @(negedge clk);
      #1;
      checkOutput("done_pulses", doneCount - d0, 32'd1);
      injAt = -1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ok;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.buf_empty = 1'b0;
    bus.buf_rdata = '0;
    bus.out_ready = 1'b0;
    #3;
    checkOutput("rst_buf_ren", bus.buf_ren, 32'd0);
    checkOutput("rst_out_valid", bus.out_valid, 32'd0);
    checkOutput("rst_out_data", bus.out_data, 32'd0);
    checkOutput("rst_busy", bus.busy, 32'd0);
    checkOutput("rst_done", bus.done, 32'd0);
    #9 rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] full-rate burst len=4");
    detData = 1'b1; dataBase = 16'hD000; rdIdx = 0;
    applyStimulus(4, -1, 1, 0, 1'b0, 1'b0, -1, 1'b1);
    checkOutput("t1_ren", renVec & 32'h3FF, 32'h01E);
    checkOutput("t1_valid", validVec & 32'h3FF, 32'h078);
    checkOutput("t1_done", doneVec & 32'h3FF, 32'h080);
    checkOutput("t1_busy", busyVec & 32'h3FF, 32'h07E);
    checkOutput("t1_count", hsQ.size(), 32'd4);
    for (int i = 0; i < 4 && i < hsQ.size(); i++) checkOutput("t1_word", hsQ[i], 32'hD000 + i);

    $display("[TB] zero length");
    applyStimulus(0, -1, 1, 0, 1'b0, 1'b0, -1, 1'b1);
    checkOutput("t0_done", doneVec & 32'h1F, 32'h02);
    checkOutput("t0_ren", renVec & 32'h1F, 32'h00);
    checkOutput("t0_valid", validVec & 32'h1F, 32'h00);
    checkOutput("t0_busy", busyVec & 32'h1F, 32'h00);

    $display("[TB] backpressure len=6");
    dataBase = 16'hD100; rdIdx = 0;
    applyStimulus(6, 9, 1, 0, 1'b0, 1'b0, -1, 1'b1);
    checkOutput("bp_ren", renVec & 32'h3FF, 32'h006);
    checkOutput("bp_hold", dataAt9, 32'hD100);
    checkOutput("bp_count", hsQ.size(), 32'd6);
    for (int i = 0; i < 6 && i < hsQ.size(); i++) checkOutput("bp_word", hsQ[i], 32'hD100 + i);

    $display("[TB] empty buffer len=3");
    dataBase = 16'hD200; rdIdx = 0;
    applyStimulus(3, -1, 1, 5, 1'b0, 1'b0, -1, 1'b1);
    checkOutput("em_ren", renVec & 32'h3FF, 32'h1C0);
    checkOutput("em_count", hsQ.size(), 32'd3);

    $display("[TB] start while busy");
    dataBase = 16'hD300; rdIdx = 0;
    applyStimulus(4, -1, 1, 0, 1'b0, 1'b0, 2, 1'b1);
    checkOutput("sb_count", hsQ.size(), 32'd4);

    $display("[TB] reset mid-burst");
    dataBase = 16'hC000; rdIdx = 0;
    applyStimulus(6, -1, 1, 0, 1'b0, 1'b0, -1, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (hsQ.size() >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("rm_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rm_out_valid", bus.out_valid, 32'd0);
    checkOutput("rm_buf_ren", bus.buf_ren, 32'd0);
    checkOutput("rm_busy", bus.busy, 32'd0);
    mState = 0; mLen = 0; mIssued = 0; mDel = 0; mInflight = 1'b0;
    mQ.delete();
    @(posedge clk);
    #3;
    rst = 1'b0;
    dataBase = 16'hE000; rdIdx = 0;
    applyStimulus(3, -1, 1, 0, 1'b0, 1'b0, -1, 1'b1);
    checkOutput("rm_count", hsQ.size(), 32'd3);
    for (int i = 0; i < 3 && i < hsQ.size(); i++) checkOutput("rm_word", hsQ[i], 32'hE000 + i);

    $display("[TB] randomized bursts");
    detData = 1'b0;
    for (int t = 0; t < 12; t++) begin
      int L;
      L = $urandom_range(1, 30);
      applyStimulus(L, -1, 1, 0, 1'b1, 1'b1, ((t % 4) == 3) ? 3 : -1, 1'b1);
      checkOutput("rnd_count", hsQ.size(), L);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
